imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-serial boot loader: the write-side counterpart to instruction_memory's read port. It fills instruction memory before the pipeline runs.
- Accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words and issues word writes at consecutive byte addresses.
- Holds the CPU (cpu_hold) until a frame loads with a verified checksum.
- Frame format: 2-byte little-endian word count N, then 4N payload bytes, then a 1-byte XOR checksum.

Parameters:
- DEPTH_BYTES, 128: instruction memory size in bytes; max words = DEPTH_BYTES/4.
- BASE_ADDR, 0: byte address of the first word written; must be a multiple of 4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data holds a valid byte
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- rearm  in  1  single-cycle pulse; restarts the loader from DONE or ERR
- wr_en  out  1  single-cycle instruction-memory write strobe
- wr_addr  out  32  byte address of the word being written
- wr_data  out  32  word to write, {b3,b2,b1,b0}
- cpu_hold  out  1  keeps the pipeline in reset/stall while high
- done  out  1  frame finished (pass or fail)
- load_ok  out  1  frame finished with no error
- err_chk  out  1  checksum mismatch
- err_ovf  out  1  N exceeded DEPTH_BYTES/4

Behaviour:
- Reset (async, active-high):
  - state=LEN0; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, load_ok=0, err_chk=0, err_ovf=0.
  - Byte counters, word index, count register, partial word and running XOR all cleared.
  - in_ready is registered: it rises on the first clk edge after reset deasserts.
- Byte acceptance: a byte is taken only on a clk edge with in_valid & in_ready. No other input changes state, apart from rearm in DONE/ERR.
- in_ready is 1 in LEN0, LEN1, LOAD and CHK (after the post-reset edge) and 0 in DONE and ERR.
- States and transitions:
  - LEN0: accept byte, N[7:0]=byte -> LEN1.
  - LEN1: accept byte, N[15:8]=byte. Go to CHK if N==0, otherwise LOAD.
  - LOAD:
    - A 2-bit lane counter places each byte at lane 0..3.
    - On acceptance of lane 3, the next edge asserts wr_en for exactly one cycle with wr_data = assembled word and wr_addr = BASE_ADDR + 4*k, where k is the word index (0-based). k then increments.
    - After word N-1 is accepted -> CHK. LOAD-to-CHK shares that edge; the wr_en for the last word still fires on it.
  - CHK: accept one byte and compare it with the running XOR of both header bytes and all payload bytes.
    - Match and err_ovf=0 -> DONE.
    - Otherwise -> ERR. err_chk=1 on mismatch; err_ovf stays as previously set.
  - DONE: done=1, load_ok=1, cpu_hold=0 (all registered).
  - ERR: done=1, load_ok=0, cpu_hold=1.
- Overflow:
  - If k >= DEPTH_BYTES/4 when a word completes, wr_en stays 0 for that word and err_ovf=1 (sticky).
  - Remaining payload bytes are still consumed so the framing stays aligned.
- Widths: N is 16 bits, k is 16 bits, and wr_addr is computed in 32 bits with no wrap check beyond the overflow rule.
- rearm:
  - Acts only in DONE or ERR: next state is LEN0, and done, load_ok, err_chk, err_ovf, k, lane and XOR are cleared. cpu_hold=1 on the same edge.
  - Ignored in every other state.
- Reset mid-operation: the partial word is discarded, no wr_en is issued for it, and already-written words are not undone.
- wr_en is never asserted in LEN0, LEN1, CHK, DONE or ERR, except the single trailing pulse for the final word on the LOAD-to-CHK edge.

Test Plan:
1. Basic load: after reset, stream 02 00 03 21 40 01 93 01 10 01 E2 with in_valid continuously high.
   - Required: wr_en pulse addr 0x0 data 0x01402103, then wr_en pulse addr 0x4 data 0x01100193.
   - Then done=1, load_ok=1, cpu_hold 1->0, in_ready=0.
2. Empty frame: 00 00 00 -> no wr_en pulses; done=1, load_ok=1, cpu_hold=0.
3. Bad checksum: frame from test 1 with a final byte of E3.
   - Required: both writes still occur; err_chk=1, load_ok=0, cpu_hold=1, in_ready=0.
   - Then pulse rearm: in_ready=1, done=0, err_chk=0, cpu_hold=1.
4. Overflow (DEPTH_BYTES=128): N=33 (21 00), 132 payload bytes, correct checksum.
   - Required: exactly 32 wr_en pulses (addr 0x00..0x7C), none for word 32; err_ovf=1, ERR state, cpu_hold=1.
5. Gappy source: test 1 bytes with in_valid toggled 1,0,0,1,... -> identical writes and flags; no byte is duplicated or dropped.
6. Reset mid-load: assert reset asynchronously after the header plus 5 payload bytes.
   - Required: outputs immediately take their reset values, with wr_en=0 throughout.
   - Then a fresh test-1 frame loads correctly from addr 0x0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: takes a framed byte stream (16-bit LE word count, payload, XOR checksum),
// writes little-endian words into instruction memory and holds the CPU until a frame verifies.
module imem_loader #(
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        rearm,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        load_ok,
  output logic        err_chk,
  output logic        err_ovf
);

  localparam logic [2:0] S_LEN0 = 3'd0;
  localparam logic [2:0] S_LEN1 = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [31:0] MAX_WORDS = 32'(DEPTH_BYTES / 4);
  localparam logic [31:0] BASE      = 32'(BASE_ADDR);

  logic [2:0]  state;
  logic [15:0] n;
  logic [15:0] k;
  logic [1:0]  lane;
  logic [23:0] part;
  logic [7:0]  xor_acc;

  logic        take;
  logic [15:0] k_next;
  logic        ovf_now;

  assign take    = in_valid & in_ready;
  assign k_next  = k + 16'd1;
  assign ovf_now = ({16'd0, k} >= MAX_WORDS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_LEN0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= 32'd0;
      wr_data  <= 32'd0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      load_ok  <= 1'b0;
      err_chk  <= 1'b0;
      err_ovf  <= 1'b0;
      n        <= 16'd0;
      k        <= 16'd0;
      lane     <= 2'd0;
      part     <= 24'd0;
      xor_acc  <= 8'd0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_LEN0: begin
          in_ready <= 1'b1;
          if (take) begin
            n[7:0]  <= in_data;
            xor_acc <= xor_acc ^ in_data;
            state   <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (take) begin
            n[15:8] <= in_data;
            xor_acc <= xor_acc ^ in_data;
            state   <= ({in_data, n[7:0]} == 16'd0) ? S_CHK : S_LOAD;
          end
        end
        S_LOAD: begin
          if (take) begin
            xor_acc <= xor_acc ^ in_data;
            lane    <= lane + 2'd1;
            case (lane)
              2'd0: part[7:0]   <= in_data;
              2'd1: part[15:8]  <= in_data;
              2'd2: part[23:16] <= in_data;
              default: begin
                // Words past the memory end are dropped but still counted so framing stays aligned.
                if (!ovf_now) begin
                  wr_en   <= 1'b1;
                  wr_addr <= BASE + {14'd0, k, 2'b00};
                  wr_data <= {in_data, part};
                end else begin
                  err_ovf <= 1'b1;
                end
                k <= k_next;
                if (k_next == n) state <= S_CHK;
              end
            endcase
          end
        end
        S_CHK: begin
          if (take) begin
            in_ready <= 1'b0;
            done     <= 1'b1;
            if (in_data == xor_acc && !err_ovf) begin
              state    <= S_DONE;
              load_ok  <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state   <= S_ERR;
              err_chk <= (in_data != xor_acc);
            end
          end
        end
        S_DONE, S_ERR: begin
          if (rearm) begin
            state    <= S_LEN0;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            load_ok  <= 1'b0;
            err_chk  <= 1'b0;
            err_ovf  <= 1'b0;
            n        <= 16'd0;
            k        <= 16'd0;
            lane     <= 2'd0;
            xor_acc  <= 8'd0;
          end
        end
        default: begin
          state    <= S_LEN0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loads, checksum/overflow errors, rearm, stalls and mid-load reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        rearm = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold, done, load_ok, err_chk, err_ovf;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  logic [7:0] frame1[11] = '{8'h02, 8'h00, 8'h03, 8'h21, 8'h40, 8'h01,
                             8'h93, 8'h01, 8'h10, 8'h01, 8'hE2};

  imem_loader #(.DEPTH_BYTES(128), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rearm(rearm), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done), .load_ok(load_ok),
    .err_chk(err_chk), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
    checks++; if (wr_addr !== 32'd0) begin errors++; $display("FAIL rst_wr_addr got %h want 0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_data got %h want 0", wr_data); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold got %b want 1", cpu_hold); end
    checks++; if ({done, load_ok, err_chk, err_ovf} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags got %b want 0000", {done, load_ok, err_chk, err_ovf}); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got %b want 1", in_ready); end
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic test_basic(input int gap, input string tag);
    for (int i = 0; i < 10; i++) send_byte(frame1[i], gap);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL %s_hold_before got %b want 1", tag, cpu_hold); end
    send_byte(frame1[10], gap);
    @(negedge clk);
    checks++; if (wa_q.size() !== 2) begin errors++; $display("FAIL %s_nwrites got %0d want 2", tag, wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h01402103) begin
        errors++; $display("FAIL %s_w0 got %h/%h want 00000000/01402103", tag, wa_q[0], wd_q[0]); end
      checks++; if (wa_q[1] !== 32'h4 || wd_q[1] !== 32'h01100193) begin
        errors++; $display("FAIL %s_w1 got %h/%h want 00000004/01100193", tag, wa_q[1], wd_q[1]); end
    end
    checks++; if ({done, load_ok, cpu_hold, in_ready, err_chk, err_ovf} !== 6'b110000) begin
      errors++; $display("FAIL %s_flags got %b want 110000 (done load_ok hold ready chk ovf)", tag,
                         {done, load_ok, cpu_hold, in_ready, err_chk, err_ovf}); end
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic test_empty();
    pulse_rearm();
    checks++; if ({in_ready, done, cpu_hold} !== 3'b101) begin
      errors++; $display("FAIL empty_rearm got %b want 101", {in_ready, done, cpu_hold}); end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL empty_nwrites got %0d want 0", wa_q.size()); end
    checks++; if ({done, load_ok, cpu_hold} !== 3'b110) begin
      errors++; $display("FAIL empty_flags got %b want 110", {done, load_ok, cpu_hold}); end
  endtask

  task automatic test_bad_chk();
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(frame1[i], 0);
    send_byte(8'hE3, 0);
    @(negedge clk);
    checks++; if (wa_q.size() !== 2) begin errors++; $display("FAIL badchk_nwrites got %0d want 2", wa_q.size()); end
    checks++; if ({done, load_ok, err_chk, err_ovf, cpu_hold, in_ready} !== 6'b101010) begin
      errors++; $display("FAIL badchk_flags got %b want 101010 (done ok chk ovf hold ready)",
                         {done, load_ok, err_chk, err_ovf, cpu_hold, in_ready}); end
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL badchk_err_hold got %b want 0", in_ready); end
    pulse_rearm();
    checks++; if ({in_ready, done, err_chk, cpu_hold} !== 4'b1001) begin
      errors++; $display("FAIL badchk_rearm got %b want 1001", {in_ready, done, err_chk, cpu_hold}); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    do_reset();
    send_byte(8'h21, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 132; i++) send_byte(8'(i), 0);
    // Payload 0..131 XORs to zero, so the checksum is just the header XOR.
    send_byte(8'h21, 0);
    @(negedge clk);
    checks++; if (wa_q.size() !== 32) begin errors++; $display("FAIL ovf_nwrites got %0d want 32", wa_q.size()); end
    for (int j = 0; j < 32 && j < wa_q.size(); j++) begin
      exp = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
      checks++;
      if (wa_q[j] !== 32'(4*j) || wd_q[j] !== exp) begin
        errors++; $display("FAIL ovf_w%0d got %h/%h want %h/%h", j, wa_q[j], wd_q[j], 32'(4*j), exp); end
    end
    checks++; if ({done, load_ok, err_chk, err_ovf, cpu_hold, in_ready} !== 6'b100110) begin
      errors++; $display("FAIL ovf_flags got %b want 100110 (done ok chk ovf hold ready)",
                         {done, load_ok, err_chk, err_ovf, cpu_hold, in_ready}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(frame1[i], 0);
    #2 reset = 1'b1;
    #1;
    checks++; if ({in_ready, wr_en, cpu_hold, done, load_ok} !== 5'b00100) begin
      errors++; $display("FAIL mid_async got %b want 00100", {in_ready, wr_en, cpu_hold, done, load_ok}); end
    checks++; if (wr_addr !== 32'd0 || wr_data !== 32'd0) begin
      errors++; $display("FAIL mid_wr_bus got %h/%h want 0/0", wr_addr, wr_data); end
    repeat (3) @(negedge clk);
    checks++; if (wa_q.size() !== 1 || wa_q[0] !== 32'h0) begin
      errors++; $display("FAIL mid_writes got n=%0d want 1 at addr 0", wa_q.size()); end
    reset = 1'b0;
    wa_q.delete();
    wd_q.delete();
    test_basic(0, "mid_reload");
  endtask

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_empty();
    test_bad_chk();
    test_overflow();
    do_reset();
    test_basic(2, "gappy");
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
